// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store initiator driving a word-wide memory port with lane placement, load extension and legality checks
module lsu_mem_if #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        men,
  output logic        mwen,
  output logic [63:0] raddr,
  input  logic [63:0] rdata,
  output logic [63:0] waddr,
  output logic [63:0] wdata,
  output logic [7:0]  wmask
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [2:0]  off;
  logic [3:0]  nbytes;
  logic        illegal;
  logic        misal;
  logic [15:0] mask_w;
  logic [63:0] sh;
  logic        sx;
  logic [63:0] ld_ext;
  assign off     = req_addr[2:0];
  assign nbytes  = 4'd1 << req_funct3[1:0];
  assign illegal = req_wen ? req_funct3[2] : &req_funct3;
  // Strict mode wants natural alignment; relaxed mode only forbids crossing the 8-byte word.
  assign misal   = ERR_ON_MISALIGN ? |(off & 3'(nbytes - 4'd1)) : (({1'b0, off} + nbytes) > 4'd8);
  assign mask_w  = ((16'd1 << nbytes) - 16'd1) << off;
  assign sh      = rdata >> {off_q, 3'b000};
  assign sx      = ~f3_q[2];
  assign ld_ext  = f3_q[1:0] == 2'd0 ? {{56{sx & sh[7]}},  sh[7:0]}  :
                   f3_q[1:0] == 2'd1 ? {{48{sx & sh[15]}}, sh[15:0]} :
                   f3_q[1:0] == 2'd2 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
  // Request FSM with every handshake and memory-port output registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      men        <= 1'b0;
      mwen       <= 1'b0;
      raddr      <= '0;
      waddr      <= '0;
      wdata      <= '0;
      wmask      <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          f3_q      <= req_funct3;
          off_q     <= off;
          req_ready <= 1'b0;
          if (illegal || misal) begin
            state_q    <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state_q <= ACCESS;
            men     <= 1'b1;
            mwen    <= req_wen;
            raddr   <= {req_addr[63:3], 3'b000};
            waddr   <= {req_addr[63:3], 3'b000};
            wdata   <= req_wdata << {off, 3'b000};
            wmask   <= mask_w[7:0];
          end
        end
        ACCESS: begin
          state_q    <= DONE;
          men        <= 1'b0;
          mwen       <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= mwen ? '0 : ld_ext;
        end
        DONE: if (resp_ready) begin
          state_q    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed checks of lsu_mem_if in strict (dut) and relaxed (dut0) alignment modes
module tb_lsu_mem_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n = 1'b0, req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, men, mwen;
  logic [63:0] resp_rdata, raddr, rdata, waddr, wdata;
  logic [7:0]  wmask;
  logic        req_ready0, resp_valid0, resp_err0, men0, mwen0;
  logic [63:0] resp_rdata0, raddr0, rdata0, waddr0, wdata0;
  logic [7:0]  wmask0;
  logic [63:0] mem [0:7] = '{default: 64'd0};
  int wr_cnt = 0, n_cmp = 0, n_err = 0;

  lsu_mem_if #(.ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .men(men), .mwen(mwen),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata), .wmask(wmask));
  lsu_mem_if #(.ERR_ON_MISALIGN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata0), .resp_err(resp_err0), .men(men0), .mwen(mwen0),
    .raddr(raddr0), .rdata(rdata0), .waddr(waddr0), .wdata(wdata0), .wmask(wmask0));

  assign rdata  = mem[raddr[5:3]];
  assign rdata0 = mem[raddr0[5:3]];

  // Byte-masked memory model; only the strict instance writes it.
  always @(posedge clk) begin
    if (men && mwen) begin
      wr_cnt <= wr_cnt + 1;
      for (int i = 0; i < 8; i++) if (wmask[i]) mem[waddr[5:3]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  task automatic send(input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_wen = w; req_funct3 = f; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, resp_valid, resp_err, men, mwen} !== 5'b10000) begin n_err++; $display("FAIL reset_ctl: got %b want 10000", {req_ready, resp_valid, resp_err, men, mwen}); end
    n_cmp++; if ({resp_rdata, raddr, waddr} !== 192'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", {resp_rdata, raddr, waddr}); end
    n_cmp++; if ({wdata, wmask} !== 72'd0) begin n_err++; $display("FAIL reset_wr: got %h want 0", {wdata, wmask}); end
    n_cmp++; if ({req_ready0, resp_valid0, men0} !== 3'b100) begin n_err++; $display("FAIL reset_dut0: got %b want 100", {req_ready0, resp_valid0, men0}); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_sd;
    send(1'b1, 3'd3, 64'h8000_0010, 64'h1122334455667788);
    @(negedge clk);
    n_cmp++; if ({men, mwen, resp_valid, raddr, waddr, wmask, wdata} !== {3'b110, 64'h8000_0010, 64'h8000_0010, 8'hFF, 64'h1122334455667788})
      begin n_err++; $display("FAIL sd_access: got %h want %h", {men, mwen, resp_valid, raddr, waddr, wmask, wdata}, {3'b110, 64'h8000_0010, 64'h8000_0010, 8'hFF, 64'h1122334455667788}); end
    @(negedge clk);
    n_cmp++; if ({men, mwen, resp_valid, resp_err, req_ready, resp_rdata} !== {5'b00100, 64'd0}) begin n_err++; $display("FAIL sd_resp: got %h want %h", {men, mwen, resp_valid, resp_err, req_ready, resp_rdata}, {5'b00100, 64'd0}); end
    n_cmp++; if (mem[2] !== 64'h1122334455667788) begin n_err++; $display("FAIL sd_mem: got %h want 1122334455667788", mem[2]); end
    @(negedge clk);
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin n_err++; $display("FAIL sd_idle: got %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_store_sb;
    send(1'b1, 3'd0, 64'h8000_0013, 64'hAB);
    @(negedge clk);
    n_cmp++; if ({men, mwen, waddr, wmask, wdata} !== {2'b11, 64'h8000_0010, 8'h08, 64'h00000000AB000000})
      begin n_err++; $display("FAIL sb_access: got %h want %h", {men, mwen, waddr, wmask, wdata}, {2'b11, 64'h8000_0010, 8'h08, 64'h00000000AB000000}); end
    @(negedge clk);
    n_cmp++; if (mem[2] !== 64'h11223344AB667788) begin n_err++; $display("FAIL sb_mem: got %h want 11223344ab667788", mem[2]); end
    @(negedge clk);
  endtask

  task automatic test_load;
    logic [2:0]  f3s [7] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd5, 3'd3, 3'd6};
    logic [63:0] ads [7] = '{64'h8000_0013, 64'h8000_0013, 64'h8000_0014, 64'h8000_0012, 64'h8000_0016, 64'h8000_0010, 64'h8000_0010};
    logic [63:0] exp [7] = '{64'hFFFFFFFFFFFFFF80, 64'h80, 64'h11223344, 64'hFFFFFFFFFFFF8066, 64'h1122, 64'h1122334480667788, 64'h80667788};
    send(1'b1, 3'd3, 64'h8000_0010, 64'h1122334480667788);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      send(1'b0, f3s[k], ads[k], 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      n_cmp++; if ({men, mwen, raddr} !== {2'b10, 64'h8000_0010}) begin n_err++; $display("FAIL load%0d_access: got %h want %h", k, {men, mwen, raddr}, {2'b10, 64'h8000_0010}); end
      @(negedge clk);
      n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, exp[k]}) begin n_err++; $display("FAIL load%0d_data: got %h want %h", k, {resp_valid, resp_err, resp_rdata}, {2'b10, exp[k]}); end
      @(negedge clk);
    end
  endtask

  task automatic test_misalign;
    send(1'b1, 3'd3, 64'h8000_0000, 64'h8877665544332211);
    repeat (3) @(negedge clk);
    send(1'b0, 3'd2, 64'h8000_0002, 64'd0);
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_err, men, req_ready, resp_rdata} !== {4'b1100, 64'd0}) begin n_err++; $display("FAIL lw_mis_strict: got %h want %h", {resp_valid, resp_err, men, req_ready, resp_rdata}, {4'b1100, 64'd0}); end
    n_cmp++; if ({men0, resp_valid0, wmask0, raddr0} !== {2'b10, 8'h3C, 64'h8000_0000}) begin n_err++; $display("FAIL lw_mis_relaxed_acc: got %h want %h", {men0, resp_valid0, wmask0, raddr0}, {2'b10, 8'h3C, 64'h8000_0000}); end
    @(negedge clk);
    n_cmp++; if ({men, resp_valid, req_ready} !== 3'b001) begin n_err++; $display("FAIL lw_mis_strict_idle: got %b want 001", {men, resp_valid, req_ready}); end
    n_cmp++; if ({resp_valid0, resp_err0, resp_rdata0} !== {2'b10, 64'h66554433}) begin n_err++; $display("FAIL lw_mis_relaxed_data: got %h want %h", {resp_valid0, resp_err0, resp_rdata0}, {2'b10, 64'h66554433}); end
    @(negedge clk);
    send(1'b0, 3'd3, 64'h8000_0002, 64'd0);
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_err, men, resp_valid0, resp_err0, men0} !== 6'b110110) begin n_err++; $display("FAIL ld_mis_both: got %b want 110110", {resp_valid, resp_err, men, resp_valid0, resp_err0, men0}); end
    @(negedge clk);
    send(1'b1, 3'd4, 64'h8000_0010, 64'd0);
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_err, men, mwen} !== 4'b1100) begin n_err++; $display("FAIL st_illegal: got %b want 1100", {resp_valid, resp_err, men, mwen}); end
    @(negedge clk);
    send(1'b0, 3'd7, 64'h8000_0010, 64'd0);
    @(negedge clk);
    n_cmp++; if ({resp_valid0, resp_err0, men0} !== 3'b110) begin n_err++; $display("FAIL ld_illegal: got %b want 110", {resp_valid0, resp_err0, men0}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    resp_ready = 1'b0;
    send(1'b0, 3'd3, 64'h8000_0010, 64'd0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({resp_valid, resp_rdata} !== {1'b1, 64'h1122334480667788}) begin n_err++; $display("FAIL bp_first: got %h want %h", {resp_valid, resp_rdata}, {1'b1, 64'h1122334480667788}); end
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd3; req_addr = 64'h8000_0018; req_wdata = 64'hCAFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if ({resp_valid, resp_err, req_ready, men, resp_rdata} !== {4'b1000, 64'h1122334480667788}) begin n_err++; $display("FAIL bp_hold%0d: got %h want %h", k, {resp_valid, resp_err, req_ready, men, resp_rdata}, {4'b1000, 64'h1122334480667788}); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ready, resp_valid, men} !== 3'b100) begin n_err++; $display("FAIL bp_release: got %b want 100", {req_ready, resp_valid, men}); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({men, mwen, waddr, wmask, wdata} !== {2'b11, 64'h8000_0018, 8'hFF, 64'hCAFE}) begin n_err++; $display("FAIL bp_next: got %h want %h", {men, mwen, waddr, wmask, wdata}, {2'b11, 64'h8000_0018, 8'hFF, 64'hCAFE}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int wc;
    wc = wr_cnt;
    send(1'b1, 3'd2, 64'h8000_0020, 64'hDEADBEEF);
    @(negedge clk);
    n_cmp++; if ({men, mwen, wmask} !== {2'b11, 8'h0F}) begin n_err++; $display("FAIL rm_access: got %h want 30f", {men, mwen, wmask}); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_cnt - wc !== 1) begin n_err++; $display("FAIL rm_writes: got %0d want 1", wr_cnt - wc); end
    n_cmp++; if (mem[4] !== 64'hDEADBEEF) begin n_err++; $display("FAIL rm_mem: got %h want deadbeef", mem[4]); end
    n_cmp++; if ({req_ready, resp_valid, resp_err, men, mwen, raddr, waddr, wdata, wmask} !== {5'b10000, 200'd0}) begin n_err++; $display("FAIL rm_values: got %h want %h", {req_ready, resp_valid, resp_err, men, mwen, raddr, waddr, wdata, wmask}, {5'b10000, 200'd0}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({resp_valid, men, req_ready} !== 3'b001) begin n_err++; $display("FAIL rm_after: got %b want 001", {resp_valid, men, req_ready}); end
    n_cmp++; if (wr_cnt - wc !== 1) begin n_err++; $display("FAIL rm_writes_after: got %0d want 1", wr_cnt - wc); end
  endtask

  initial begin
    test_reset;
    test_store_sd;
    test_store_sb;
    test_load;
    test_misalign;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
